// File: rtl/ascon_rc_pkg.sv
// rtl/ascon_rc_pkg.sv - shared constants and state type for the Ascon round-constant sequencer
package ascon_rc_pkg;

   localparam int         MAX_ROUNDS = 12;
   localparam logic [7:0] RC_BASE    = 8'hF0;
   localparam logic [7:0] RC_STEP    = 8'd15;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rc_state_t;

endpackage

// File: rtl/rc_lane.sv
// rtl/rc_lane.sv - combinational Ascon round constant for one constant index
module rc_lane
   import ascon_rc_pkg::*;
(
   input  logic [4:0] idx_i,
   output logic [7:0] rc_o
);

   logic [7:0] step_prod;

   // c_i = 0xF0 - 15*i, all arithmetic modulo 256
   assign step_prod = RC_STEP * {3'b000, idx_i};
   assign rc_o      = RC_BASE - step_prod;

endmodule

// File: rtl/roundconstant_seq.sv
// rtl/roundconstant_seq.sv - Ascon round-constant sequencer, UNROLL lanes per beat; optional abort_i under ROUNDCONST_ABORT_EN
module roundconstant_seq
   import ascon_rc_pkg::*;
#(
   parameter int UNROLL = 1
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [4:0]          rounds_i,
   input  logic                adv_i,
`ifdef ROUNDCONST_ABORT_EN
   input  logic                abort_i,
`endif
   output logic                ready_o,
   output logic                vld_o,
   output logic [8*UNROLL-1:0] rc_o,
   output logic [UNROLL-1:0]   lane_vld_o,
   output logic [4:0]          idx_o,
   output logic                last_o,
   output logic                done_o,
   output logic                err_o
);

   localparam logic [4:0] UNROLL_W = 5'(UNROLL);
   localparam logic [4:0] MAX_W    = 5'(MAX_ROUNDS);

   rc_state_t  state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] rem_q, rem_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       run;
   logic       last;
   logic       legal;
   logic       abort;

`ifdef ROUNDCONST_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign run   = (state_q == RUN);
   assign last  = run && (rem_q <= UNROLL_W);
   assign legal = (rounds_i != 5'd0) && (rounds_i <= MAX_W);

   // State, index and remaining-count registers; outputs derive only from these
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         rem_q   <= 5'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state: accept/reject starts in IDLE, step or finish beats in RUN
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (legal) begin
                  state_d = RUN;
                  idx_d   = MAX_W - rounds_i;
                  rem_d   = rounds_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (adv_i) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + UNROLL_W;
                  rem_d = rem_q - UNROLL_W;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One constant generator per lane; lanes past the remaining count are masked to zero
   for (genvar k = 0; k < UNROLL; k++) begin : g_lane
      logic [7:0] lane_rc;
      logic       lane_on;

      rc_lane u_rc_lane (
         .idx_i (idx_q + 5'(k)),
         .rc_o  (lane_rc)
      );

      assign lane_on          = run && (rem_q > 5'(k));
      assign lane_vld_o[k]    = lane_on;
      assign rc_o[8*k +: 8]   = lane_on ? lane_rc : 8'h00;
   end

   assign ready_o = (state_q == IDLE);
   assign vld_o   = run;
   assign idx_o   = run ? idx_q : 5'd0;
   assign last_o  = last;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_roundconstant_seq.sv
// tb/tb_roundconstant_seq.sv - randomized self-checking bench for roundconstant_seq at UNROLL 1, 2 and 4
module tb_roundconstant_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s  [3];
   logic [4:0] rounds_s [3];
   logic       adv_s    [3];
`ifdef ROUNDCONST_ABORT_EN
   logic       abort_s  [3];
`endif

   logic       ready_w [3];
   logic       vld_w   [3];
   logic       last_w  [3];
   logic       done_w  [3];
   logic       err_w   [3];
   logic [4:0] idx_w   [3];
   logic [7:0]  rc1;
   logic [15:0] rc2;
   logic [31:0] rc4;
   logic [0:0]  m1;
   logic [1:0]  m2;
   logic [3:0]  m4;
   logic [31:0] obs_rc   [3];
   logic [3:0]  obs_mask [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign obs_rc[0]   = {24'h0, rc1};
   assign obs_rc[1]   = {16'h0, rc2};
   assign obs_rc[2]   = rc4;
   assign obs_mask[0] = {3'b000, m1};
   assign obs_mask[1] = {2'b00, m2};
   assign obs_mask[2] = m4;

   roundconstant_seq #(.UNROLL(1)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start_s[0]), .rounds_i(rounds_s[0]), .adv_i(adv_s[0]),
`ifdef ROUNDCONST_ABORT_EN
      .abort_i(abort_s[0]),
`endif
      .ready_o(ready_w[0]), .vld_o(vld_w[0]), .rc_o(rc1), .lane_vld_o(m1), .idx_o(idx_w[0]),
      .last_o(last_w[0]), .done_o(done_w[0]), .err_o(err_w[0])
   );

   roundconstant_seq #(.UNROLL(2)) u_dut2 (
      .clk(clk), .rst(rst), .start_i(start_s[1]), .rounds_i(rounds_s[1]), .adv_i(adv_s[1]),
`ifdef ROUNDCONST_ABORT_EN
      .abort_i(abort_s[1]),
`endif
      .ready_o(ready_w[1]), .vld_o(vld_w[1]), .rc_o(rc2), .lane_vld_o(m2), .idx_o(idx_w[1]),
      .last_o(last_w[1]), .done_o(done_w[1]), .err_o(err_w[1])
   );

   roundconstant_seq #(.UNROLL(4)) u_dut4 (
      .clk(clk), .rst(rst), .start_i(start_s[2]), .rounds_i(rounds_s[2]), .adv_i(adv_s[2]),
`ifdef ROUNDCONST_ABORT_EN
      .abort_i(abort_s[2]),
`endif
      .ready_o(ready_w[2]), .vld_o(vld_w[2]), .rc_o(rc4), .lane_vld_o(m4), .idx_o(idx_w[2]),
      .last_o(last_w[2]), .done_o(done_w[2]), .err_o(err_w[2])
   );

   function automatic int unr(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
   endfunction

   // Reference: beat b of a run of r rounds covers positions b*u .. b*u+u-1 of the index list 12-r..11
   function automatic logic [31:0] exp_rc(input int u, input int r, input int b);
      logic [31:0] v;
      logic [7:0]  c;
      v = '0;
      for (int k = 0; k < u; k++) begin
         if (b*u + k < r) begin
            c = 8'(240 - 15*(12 - r + b*u + k));
            v[8*k +: 8] = c;
         end
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_mask(input int u, input int r, input int b);
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < u; k++)
         if (b*u + k < r) m[k] = 1'b1;
      return m;
   endfunction

   // Entered and left at a falling edge; starts a run on DUT sel and checks every beat against the model
   task automatic run_and_check(input int sel, input int r, input bit rand_adv);
      int u;
      int nb;
      int b;
      int cyc;
      bit a;
      u   = unr(sel);
      nb  = (r + u - 1) / u;
      b   = 0;
      cyc = 0;
      checks++;
      if (ready_w[sel] !== 1'b1) begin
         errors++;
         $display("FAIL run_ready sel=%0d got=%b exp=1", sel, ready_w[sel]);
      end
      start_s[sel]  = 1'b1;
      rounds_s[sel] = 5'(r);
      @(posedge clk); #1;
      start_s[sel] = 1'b0;
      rounds_s[sel] = 5'($urandom_range(0, 31));
      while (b < nb && cyc < 400) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (vld_w[sel] !== 1'b1 || ready_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL beat_vld sel=%0d r=%0d b=%0d got vld=%b ready=%b exp vld=1 ready=0", sel, r, b, vld_w[sel], ready_w[sel]);
         end
         checks++;
         if (obs_rc[sel] !== exp_rc(u, r, b)) begin
            errors++;
            $display("FAIL beat_rc sel=%0d r=%0d b=%0d got=%h exp=%h", sel, r, b, obs_rc[sel], exp_rc(u, r, b));
         end
         checks++;
         if (obs_mask[sel] !== exp_mask(u, r, b)) begin
            errors++;
            $display("FAIL beat_mask sel=%0d r=%0d b=%0d got=%b exp=%b", sel, r, b, obs_mask[sel], exp_mask(u, r, b));
         end
         checks++;
         if (idx_w[sel] !== 5'(12 - r + b*u)) begin
            errors++;
            $display("FAIL beat_idx sel=%0d r=%0d b=%0d got=%0d exp=%0d", sel, r, b, idx_w[sel], 12 - r + b*u);
         end
         checks++;
         if (last_w[sel] !== ((r - b*u) <= u)) begin
            errors++;
            $display("FAIL beat_last sel=%0d r=%0d b=%0d got=%b exp=%b", sel, r, b, last_w[sel], ((r - b*u) <= u));
         end
         a = rand_adv ? ($urandom_range(0, 2) != 0) : 1'b1;
         adv_s[sel] = a;
         if (a) b++;
      end
      checks++;
      if (b < nb) begin
         errors++;
         $display("FAIL run_timeout sel=%0d r=%0d got beats=%0d exp=%0d", sel, r, b, nb);
      end
      @(posedge clk); #1;
      adv_s[sel] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[sel] !== 1'b1 || ready_w[sel] !== 1'b1 || vld_w[sel] !== 1'b0) begin
         errors++;
         $display("FAIL run_done sel=%0d r=%0d got done=%b ready=%b vld=%b exp 1 1 0", sel, r, done_w[sel], ready_w[sel], vld_w[sel]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         start_s[s] = 1'b0; rounds_s[s] = 5'd0; adv_s[s] = 1'b0;
`ifdef ROUNDCONST_ABORT_EN
         abort_s[s] = 1'b0;
`endif
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (ready_w[s] !== 1'b1 || vld_w[s] !== 1'b0 || last_w[s] !== 1'b0 || done_w[s] !== 1'b0 ||
             err_w[s] !== 1'b0 || obs_rc[s] !== 32'h0 || obs_mask[s] !== 4'h0 || idx_w[s] !== 5'd0) begin
            errors++;
            $display("FAIL reset_state sel=%0d got ready=%b vld=%b last=%b done=%b err=%b rc=%h mask=%b idx=%0d exp 1 0 0 0 0 0 0 0",
                     s, ready_w[s], vld_w[s], last_w[s], done_w[s], err_w[s], obs_rc[s], obs_mask[s], idx_w[s]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_plan_runs();
      run_and_check(0, 6, 1'b0);
      @(negedge clk);
      checks++;
      if (done_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width got=%b exp=0", done_w[0]);
      end
      run_and_check(0, 12, 1'b0);
      @(negedge clk);
      run_and_check(1, 8, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_partial_beat();
      start_s[2] = 1'b1; rounds_s[2] = 5'd6;
      @(posedge clk); #1;
      start_s[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (rc4 !== 32'h69788796 || m4 !== 4'b1111 || last_w[2] !== 1'b0) begin
         errors++;
         $display("FAIL u4_beat0 got rc=%h mask=%b last=%b exp rc=69788796 mask=1111 last=0", rc4, m4, last_w[2]);
      end
      adv_s[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (rc4 !== 32'h00004B5A || m4 !== 4'b0011 || last_w[2] !== 1'b1) begin
         errors++;
         $display("FAIL u4_beat1 got rc=%h mask=%b last=%b exp rc=00004b5a mask=0011 last=1", rc4, m4, last_w[2]);
      end
      @(posedge clk); #1;
      adv_s[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[2] !== 1'b1 || vld_w[2] !== 1'b0) begin
         errors++;
         $display("FAIL u4_done got done=%b vld=%b exp 1 0", done_w[2], vld_w[2]);
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      start_s[1] = 1'b1; rounds_s[1] = 5'd8;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      @(negedge clk);
      adv_s[1] = 1'b0;
      for (int h = 0; h < 4; h++) begin
         checks++;
         if (rc2 !== 16'hA5B4 || vld_w[1] !== 1'b1 || idx_w[1] !== 5'd4) begin
            errors++;
            $display("FAIL stall_hold h=%0d got rc=%h vld=%b idx=%0d exp rc=a5b4 vld=1 idx=4", h, rc2, vld_w[1], idx_w[1]);
         end
         if (h == 3) adv_s[1] = 1'b1;
         else @(negedge clk);
      end
      for (int b = 1; b < 4; b++) begin
         @(negedge clk);
         checks++;
         if (obs_rc[1] !== exp_rc(2, 8, b) || idx_w[1] !== 5'(4 + 2*b)) begin
            errors++;
            $display("FAIL stall_resume b=%0d got rc=%h idx=%0d exp rc=%h idx=%0d", b, obs_rc[1], idx_w[1], exp_rc(2, 8, b), 4 + 2*b);
         end
      end
      checks++;
      if (rc2 !== 16'h4B5A || last_w[1] !== 1'b1) begin
         errors++;
         $display("FAIL stall_final got rc=%h last=%b exp rc=4b5a last=1", rc2, last_w[1]);
      end
      @(posedge clk); #1;
      adv_s[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[1] !== 1'b1) begin
         errors++;
         $display("FAIL stall_done got=%b exp=1", done_w[1]);
      end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3];
      bad[0] = 5'd0;
      bad[1] = 5'd13;
      bad[2] = 5'($urandom_range(14, 31));
      for (int i = 0; i < 3; i++) begin
         start_s[0] = 1'b1; rounds_s[0] = bad[i];
         @(posedge clk); #1;
         start_s[0] = 1'b0;
         @(negedge clk);
         checks++;
         if (err_w[0] !== 1'b1 || vld_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err rounds=%0d got err=%b vld=%b ready=%b exp 1 0 1", bad[i], err_w[0], vld_w[0], ready_w[0]);
         end
         @(negedge clk);
         checks++;
         if (err_w[0] !== 1'b0 || vld_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse rounds=%0d got err=%b vld=%b exp 0 0", bad[i], err_w[0], vld_w[0]);
         end
      end
   endtask

   task automatic test_busy_and_rst();
      start_s[0] = 1'b1; rounds_s[0] = 5'd12;
      @(posedge clk); #1;
      rounds_s[0] = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (err_w[0] !== 1'b0 || idx_w[0] !== 5'd0 || vld_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore i=%0d got err=%b idx=%0d vld=%b exp 0 0 1", i, err_w[0], idx_w[0], vld_w[0]);
         end
      end
      start_s[0] = 1'b0;
      adv_s[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (idx_w[0] !== 5'd2 || rc1 !== 8'hD2) begin
         errors++;
         $display("FAIL busy_progress got idx=%0d rc=%h exp idx=2 rc=d2", idx_w[0], rc1);
      end
      rst = 1'b1; start_s[0] = 1'b1; rounds_s[0] = 5'd6;
      @(negedge clk);
      checks++;
      if (ready_w[0] !== 1'b1 || vld_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rc1 !== 8'h00 ||
          m1 !== 1'b0 || idx_w[0] !== 5'd0 || last_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got ready=%b vld=%b done=%b rc=%h mask=%b idx=%0d last=%b exp 1 0 0 00 0 0 0",
                  ready_w[0], vld_w[0], done_w[0], rc1, m1, idx_w[0], last_w[0]);
      end
      rst = 1'b0; start_s[0] = 1'b0; adv_s[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_no_done got done=%b ready=%b exp 0 1", done_w[0], ready_w[0]);
      end
   endtask

`ifdef ROUNDCONST_ABORT_EN
   task automatic test_abort();
      start_s[2] = 1'b1; rounds_s[2] = 5'd12;
      @(posedge clk); #1;
      start_s[2] = 1'b0;
      @(negedge clk);
      adv_s[2] = 1'b1; abort_s[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (ready_w[2] !== 1'b1 || vld_w[2] !== 1'b0 || done_w[2] !== 1'b0 || rc4 !== 32'h0 || m4 !== 4'h0 || idx_w[2] !== 5'd0) begin
         errors++;
         $display("FAIL abort_mid got ready=%b vld=%b done=%b rc=%h mask=%b idx=%0d exp 1 0 0 0 0 0",
                  ready_w[2], vld_w[2], done_w[2], rc4, m4, idx_w[2]);
      end
      adv_s[2] = 1'b0; abort_s[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[2] !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done got=%b exp=0", done_w[2]);
      end
   endtask
`endif

   task automatic test_back_to_back();
      run_and_check(2, 6, 1'b0);
      run_and_check(2, 12, 1'b0);
      run_and_check(1, 5, 1'b1);
      run_and_check(1, 1, 1'b0);
      @(negedge clk);
      checks++;
      if (done_w[1] !== 1'b0 || done_w[2] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_clear got d1=%b d2=%b exp 0 0", done_w[1], done_w[2]);
      end
   endtask

   task automatic test_random();
      int sel;
      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(0, 2);
         run_and_check(sel, $urandom_range(1, 12), 1'b1);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_plan_runs();
      test_partial_beat();
      test_stall();
      test_illegal();
      test_busy_and_rst();
`ifdef ROUNDCONST_ABORT_EN
      test_abort();
`endif
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
